// File: rtl/clk_divider.sv
// Integer clock divider: clk_100MHz / N with tick strobe, runtime divisor and lock flag.
// Define CLKDIV_ODD_DUTY50_EN to add a negedge flop that trims odd-N output to 50 % duty.
module clk_divider #(
  parameter int  DIV_DEFAULT = 10,
  parameter int  MAX_DIV     = 256,
  parameter int  LOCK_CYCLES = 2,
  localparam int CNT_W       = $clog2(MAX_DIV),
  localparam int LOCK_W      = $clog2(LOCK_CYCLES + 1)
) (
  input  logic             clk_100MHz,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             div_load,
  input  logic [CNT_W:0]   div_value,
  output logic             clk_10MHz,
  output logic             tick,
  output logic             locked
);

  localparam logic [CNT_W:0]    N_RST    = (CNT_W + 1)'(DIV_DEFAULT);
  localparam logic [CNT_W:0]    H_RST    = (CNT_W + 1)'((DIV_DEFAULT + 1) / 2);
  localparam logic [CNT_W-1:0]  CNT_RST  = CNT_W'(DIV_DEFAULT - 1);
  localparam logic [CNT_W:0]    DIV_MIN  = (CNT_W + 1)'(2);
  localparam logic [CNT_W:0]    DIV_MAX  = (CNT_W + 1)'(MAX_DIV);
  localparam logic [CNT_W:0]    ONE_N    = (CNT_W + 1)'(1);
  localparam logic [CNT_W-1:0]  ONE_C    = CNT_W'(1);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CYCLES);
  localparam logic [LOCK_W-1:0] ONE_L    = LOCK_W'(1);

  logic [CNT_W:0]    n_q, n_d;
  logic [CNT_W:0]    h_q, h_d;
  logic [CNT_W:0]    pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              q_q, q_d;
  logic              tick_q, tick_d;
  logic [LOCK_W-1:0] lock_q, lock_d;

  logic [CNT_W:0]    div_clamped;
  logic [CNT_W:0]    n_minus1;
  logic [CNT_W:0]    pend_half;
  logic [CNT_W-1:0]  cnt_inc;
  logic              wrap;

  always_comb begin
    div_clamped = div_value;
    if (div_value < DIV_MIN) begin
      div_clamped = DIV_MIN;
    end else if (div_value > DIV_MAX) begin
      div_clamped = DIV_MAX;
    end
  end

  assign n_minus1  = n_q - ONE_N;
  assign wrap      = ({1'b0, cnt_q} == n_minus1);
  assign cnt_inc   = cnt_q + ONE_C;
  // High count for the next period is ceil(N/2) of the pending divisor.
  assign pend_half = (pend_q + ONE_N) >> 1;

  always_comb begin
    n_d    = n_q;
    h_d    = h_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    q_d    = q_q;
    tick_d = 1'b0;
    lock_d = lock_q;

    if (div_load) begin
      pend_d = div_clamped;
    end

    if (enable) begin
      if (wrap) begin
        // New divisor only at a period boundary, so no runt pulses.
        cnt_d  = '0;
        q_d    = 1'b1;
        tick_d = 1'b1;
        n_d    = pend_q;
        h_d    = pend_half;
        if (lock_q != LOCK_MAX) begin
          lock_d = lock_q + ONE_L;
        end
      end else begin
        cnt_d = cnt_inc;
        if ({1'b0, cnt_inc} == h_q) begin
          q_d = 1'b0;
        end
      end
    end

    if (div_load) begin
      lock_d = '0;
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      n_q    <= N_RST;
      h_q    <= H_RST;
      pend_q <= N_RST;
      cnt_q  <= CNT_RST;
      q_q    <= 1'b0;
      tick_q <= 1'b0;
      lock_q <= '0;
    end else begin
      n_q    <= n_d;
      h_q    <= h_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      tick_q <= tick_d;
      lock_q <= lock_d;
    end
  end

  assign tick   = tick_q;
  assign locked = (lock_q == LOCK_MAX);

`ifdef CLKDIV_ODD_DUTY50_EN
  logic qn_q;

  always_ff @(negedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      qn_q <= 1'b0;
    end else begin
      qn_q <= q_q;
    end
  end

  // Odd N: rising edge slips half a cycle, trimming high time to N/2.
  assign clk_10MHz = n_q[0] ? (q_q & qn_q) : q_q;
`else
  assign clk_10MHz = q_q;
`endif

endmodule

// File: tb/tb_clk_divider.sv
// Directed bench for clk_divider: reset, lock, reprogram, clamp, enable hold, odd divisor.
`timescale 1ns/1ps
module tb_clk_divider;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       dl;
  logic [8:0] dv;
  logic       clk_out;
  logic       tick;
  logic       locked;

  int n_tests;
  int n_fail;

  clk_divider dut (
    .clk_100MHz (clk),
    .reset_n    (rst_n),
    .enable     (en),
    .div_load   (dl),
    .div_value  (dv),
    .clk_10MHz  (clk_out),
    .tick       (tick),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!tick && n < 600);
    check(tag, tick, 1);
  endtask

  task automatic load(input int v);
    dv = 9'(v);
    dl = 1'b1;
    step(1);
    dl = 1'b0;
  endtask

  // Samples every half source cycle; returns high/low time of the next full output period.
  task automatic measure(output int hi_ns, output int lo_ns);
    int   guard;
    logic prev;
    hi_ns = 0;
    lo_ns = 0;
    guard = 0;
    prev  = clk_out;
    while (guard < 1200) begin
      #5;
      guard++;
      if (!prev && clk_out) break;
      prev = clk_out;
    end
    while (clk_out && hi_ns < 5000) begin
      hi_ns += 5;
      #5;
    end
    while (!clk_out && lo_ns < 5000) begin
      lo_ns += 5;
      #5;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, lo, c, rises, ticks, tick_bad, high_cyc, first_lock;
    logic prev;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    en    = 1'b1;
    dl    = 1'b0;
    dv    = '0;

    #50;
    check("reset_clk", clk_out, 0);
    check("reset_tick", tick, 0);
    check("reset_locked", locked, 0);
    #51;
    rst_n = 1'b1;

    // 100 cycles after release: 10 periods of N=10
    rises = 0; ticks = 0; tick_bad = 0; high_cyc = 0; first_lock = -1;
    prev = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (clk_out && !prev) rises++;
      if (tick) ticks++;
      if (tick != (clk_out && !prev)) tick_bad++;
      if (clk_out) high_cyc++;
      if (locked && first_lock < 0) first_lock = i;
      prev = clk_out;
    end
    check("rises_1000ns", rises, 10);
    check("ticks_1000ns", ticks, 10);
    check("tick_align", tick_bad, 0);
    check("high_cycles", high_cyc, 50);
    check("first_lock_cycle", first_lock, 10);
    measure(hi, lo);
    check("n10_high_ns", hi, 50);
    check("n10_low_ns", lo, 50);

    // Reprogram to 4 mid-period (cnt=3)
    wait_tick("sync_tick");
    step(3);
    load(4);
    check("reprog_lock_drop", locked, 0);
    c = 0;
    do begin step(1); c++; end while (!tick && c < 50);
    check("reprog_cycles_to_wrap", c, 6);
    check("reprog_lock_at_switch", locked, 0);
    c = 0;
    do begin step(1); c++; end while (!locked && c < 50);
    check("reprog_cycles_to_lock", c, 4);
    measure(hi, lo);
    check("n4_high_ns", hi, 20);
    check("n4_low_ns", lo, 20);

    // Last write wins
    load(6);
    load(8);
    check("lww_lock", locked, 0);
    wait_tick("lww_tick");
    measure(hi, lo);
    check("n8_high_ns", hi, 40);
    check("n8_low_ns", lo, 40);

    // Clamp low / high
    load(0);
    wait_tick("clamp0_tick");
    measure(hi, lo);
    check("clamp0_high_ns", hi, 10);
    check("clamp0_low_ns", lo, 10);
    step(1);
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (tick) ticks++;
    end
    check("n2_ticks_10cyc", ticks, 5);
    load(488);  // 1000 truncated to the 9-bit port
    wait_tick("clamphi_tick");
    measure(hi, lo);
    check("clamphi_high_ns", hi, 1280);
    check("clamphi_low_ns", lo, 1280);
    load(1);
    wait_tick("clamp1_tick");
    measure(hi, lo);
    check("clamp1_high_ns", hi, 10);
    check("clamp1_low_ns", lo, 10);

    // Enable hold while output high (cnt=2)
    load(10);
    wait_tick("en_tick_a");
    wait_tick("en_tick_b");
    step(2);
    en = 1'b0;
    high_cyc = 0;
    ticks = 0;
    for (int i = 0; i < 7; i++) begin
      step(1);
      if (clk_out) high_cyc++;
      if (tick) ticks++;
    end
    check("hold_high", high_cyc, 7);
    check("hold_ticks", ticks, 0);
    en = 1'b1;
    c = 0;
    do begin step(1); c++; end while (clk_out && c < 50);
    check("resume_high_cycles", c, 3);
    c = 0;
    do begin step(1); c++; end while (!tick && c < 50);
    check("resume_low_cycles", c, 5);

    // Odd divisor
    load(5);
    wait_tick("odd_tick");
    measure(hi, lo);
`ifdef CLKDIV_ODD_DUTY50_EN
    check("n5_high_ns", hi, 25);
    check("n5_low_ns", lo, 25);
`else
    check("n5_high_ns", hi, 30);
    check("n5_low_ns", lo, 20);
`endif

    // Reset mid-run while output high
    c = 0;
    do begin step(1); c++; end while (!clk_out && c < 50);
    check("pre_reset_high", clk_out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_clk", clk_out, 0);
    check("async_reset_locked", locked, 0);
    #20;
    rst_n = 1'b1;
    step(1);
    check("post_reset_tick", tick, 1);
    check("post_reset_clk", clk_out, 1);
    measure(hi, lo);
    check("post_reset_high_ns", hi, 50);
    check("post_reset_low_ns", lo, 50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
